mem_port: RTL and testbench

MEM_PORT -- requirements
Module: mem_port

---
 rtl/mem_port_pkg.sv | 37 +++
 rtl/mem_req_arbiter.sv | 26 ++
 rtl/mem_port.sv | 145 ++++++++++++++
 tb/tb_mem_port.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared types and defaults for the mem_port memory/IO access block.
// Holds FSM state encodings, request-kind encodings and default widths.
package mem_port_pkg;

    localparam int MP_ADDR_WIDTH = 16;
    localparam int MP_DATA_WIDTH = 16;
    localparam int MP_TIMEOUT    = 255;

    typedef enum logic [1:0] {
        MP_IDLE   = 2'd0,
        MP_ACCESS = 2'd1,
        MP_DONE   = 2'd2
    } mp_state_t;

    // RK_NONE is the reset value of the latched request kind.
    typedef enum logic [2:0] {
        RK_NONE  = 3'd0,
        RK_FETCH = 3'd1,
        RK_LOAD  = 3'd2,
        RK_STORE = 3'd3,
        RK_IN    = 3'd4,
        RK_OUT   = 3'd5
    } req_kind_t;

    function automatic logic rk_is_read(input req_kind_t k);
        return (k == RK_FETCH) || (k == RK_LOAD) || (k == RK_IN);
    endfunction

    function automatic logic rk_is_write(input req_kind_t k);
        return (k == RK_STORE) || (k == RK_OUT);
    endfunction

    function automatic logic rk_is_io(input req_kind_t k);
        return (k == RK_IN) || (k == RK_OUT);
    endfunction

endpackage

// File: rtl/mem_req_arbiter.sv
// Fixed-priority request selector: fetch > load > store > in > out.
// Purely combinational; losing requests are simply not reported.
module mem_req_arbiter
    import mem_port_pkg::*;
(
    input  logic      req_fetch,
    input  logic      req_load,
    input  logic      req_store,
    input  logic      req_in,
    input  logic      req_out,
    output logic      valid,
    output req_kind_t kind
);

    assign valid = req_fetch | req_load | req_store | req_in | req_out;

    always_comb begin
        kind = RK_NONE;
        if (req_fetch)      kind = RK_FETCH;
        else if (req_load)  kind = RK_LOAD;
        else if (req_store) kind = RK_STORE;
        else if (req_in)    kind = RK_IN;
        else if (req_out)   kind = RK_OUT;
    end

endmodule

// File: rtl/mem_port.sv
// Memory/IO access port: one outstanding bus access, IDLE -> ACCESS -> DONE.
// Optional access timeout is enabled with the MEM_PORT_TIMEOUT_EN macro.
//
// state     | meaning
// MP_IDLE   | waiting for a request, bus strobes low
// MP_ACCESS | strobes driven from latched request until bus_ready
// MP_DONE   | one-cycle done pulse, then back to IDLE
module mem_port
    import mem_port_pkg::*;
#(
    parameter int ADDR_WIDTH = MP_ADDR_WIDTH,
    parameter int DATA_WIDTH = MP_DATA_WIDTH,
    parameter int TIMEOUT    = MP_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_fetch,
    input  logic                  req_load,
    input  logic                  req_store,
    input  logic                  req_in,
    input  logic                  req_out,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic                  bus_rd,
    output logic                  bus_wr,
    output logic                  bus_io,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_ready
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_port: TIMEOUT must be at least 1");
    end

    mp_state_t state;
    req_kind_t req_kind;
    req_kind_t arb_kind;
    logic      arb_valid;

    mem_req_arbiter u_arb (
        .req_fetch (req_fetch),
        .req_load  (req_load),
        .req_store (req_store),
        .req_in    (req_in),
        .req_out   (req_out),
        .valid     (arb_valid),
        .kind      (arb_kind)
    );

`ifdef MEM_PORT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Abort fires on the edge that would make the count reach TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MP_IDLE;
            req_kind  <= RK_NONE;
            instr     <= '0;
            rdata     <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bus_rd    <= 1'b0;
            bus_wr    <= 1'b0;
            bus_io    <= 1'b0;
`ifdef MEM_PORT_TIMEOUT_EN
            err       <= 1'b0;
            wait_cnt  <= '0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MEM_PORT_TIMEOUT_EN
            err  <= 1'b0;
`endif
            case (state)
                MP_IDLE: begin
                    if (arb_valid) begin
                        state     <= MP_ACCESS;
                        req_kind  <= arb_kind;
                        bus_addr  <= addr;
                        bus_wdata <= wdata;
                        busy      <= 1'b1;
                        bus_rd    <= rk_is_read(arb_kind);
                        bus_wr    <= rk_is_write(arb_kind);
                        bus_io    <= rk_is_io(arb_kind);
`ifdef MEM_PORT_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end
                end
                MP_ACCESS: begin
                    if (bus_ready) begin
                        state  <= MP_DONE;
                        done   <= 1'b1;
                        bus_rd <= 1'b0;
                        bus_wr <= 1'b0;
                        bus_io <= 1'b0;
                        if (req_kind == RK_FETCH)
                            instr <= bus_rdata;
                        else if (rk_is_read(req_kind))
                            rdata <= bus_rdata;
                    end
`ifdef MEM_PORT_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        state    <= MP_IDLE;
                        err      <= 1'b1;
                        busy     <= 1'b0;
                        bus_rd   <= 1'b0;
                        bus_wr   <= 1'b0;
                        bus_io   <= 1'b0;
                        wait_cnt <= wait_cnt + 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                MP_DONE: begin
                    state <= MP_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= MP_IDLE;
                    busy   <= 1'b0;
                    bus_rd <= 1'b0;
                    bus_wr <= 1'b0;
                    bus_io <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port.sv
// Self-checking bench for mem_port: vector table, corner sequences, random traffic.
// Timeout sequence runs only when built with MEM_PORT_TIMEOUT_EN.
module tb_mem_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_fetch, req_load, req_store, req_in, req_out;
    logic [15:0] addr, wdata;
    logic [15:0] instr, rdata;
    logic        busy, done, err;
    logic [15:0] bus_addr, bus_wdata;
    logic        bus_rd, bus_wr, bus_io;
    logic [15:0] bus_rdata;
    logic        bus_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_instr, m_rdata;

    always #5 clk = ~clk;

    mem_port #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_fetch(req_fetch), .req_load(req_load), .req_store(req_store),
        .req_in(req_in), .req_out(req_out),
        .addr(addr), .wdata(wdata),
        .instr(instr), .rdata(rdata),
        .busy(busy), .done(done), .err(err),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_io(bus_io),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );

`ifdef MEM_PORT_TIMEOUT_EN
    localparam int WMAX = 3;
`else
    localparam int WMAX = 6;
`endif

    // request bit order: [0]=fetch [1]=load [2]=store [3]=in [4]=out
    typedef struct {
        logic [4:0]  reqs;
        logic [15:0] a;
        logic [15:0] w;
        logic [15:0] brd;
        int          waits;
        logic        e_rd, e_wr, e_io;
        logic [15:0] e_instr;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_reqs(input logic [4:0] r);
        {req_out, req_in, req_store, req_load, req_fetch} = r;
    endtask

    // Issue one request at the current negedge and follow it to IDLE.
    task automatic txn(input string tag, input logic [4:0] r, input logic [15:0] a,
                       input logic [15:0] w, input logic [15:0] brd, input int waits,
                       input logic e_rd, input logic e_wr, input logic e_io,
                       input logic [15:0] e_instr, input logic [15:0] e_rdata);
        set_reqs(r);
        addr      = a;
        wdata     = w;
        bus_rdata = brd;
        bus_ready = 1'b0;
        @(negedge clk);
        set_reqs(5'b0);
        addr  = ~a;
        wdata = ~w;
        for (int c = 0; c <= waits; c++) begin
            bus_ready = (c == waits);
            check({tag, " access strobes"}, {busy, bus_rd, bus_wr, bus_io, done, err},
                  {1'b1, e_rd, e_wr, e_io, 2'b00});
            check({tag, " bus_addr"}, bus_addr, a);
            check({tag, " bus_wdata"}, bus_wdata, w);
            @(negedge clk);
        end
        bus_ready = 1'b0;
        bus_rdata = ~brd;
        check({tag, " done strobes"}, {busy, bus_rd, bus_wr, bus_io, done, err}, 6'b100010);
        check({tag, " instr"}, instr, e_instr);
        check({tag, " rdata"}, rdata, e_rdata);
        @(negedge clk);
        check({tag, " idle strobes"}, {busy, bus_rd, bus_wr, bus_io, done, err}, 6'b000000);
    endtask

    // Reference: winner is the lowest set bit; read/write/io sets by kind.
    function automatic int winner(input logic [4:0] r);
        for (int i = 0; i < 5; i++)
            if (r[i]) return i;
        return -1;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rd_set [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic wr_set [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic io_set [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        vecs[0] = '{5'b00001, 16'h0010, 16'h0000, 16'hA5C3, 0, 1'b1, 1'b0, 1'b0, 16'hA5C3, 16'h0000};
        vecs[1] = '{5'b00100, 16'h0200, 16'h1234, 16'hDEAD, 3, 1'b0, 1'b1, 1'b0, 16'hA5C3, 16'h0000};
        vecs[2] = '{5'b10010, 16'h0300, 16'h0F0F, 16'h00FF, 0, 1'b1, 1'b0, 1'b0, 16'hA5C3, 16'h00FF};
        vecs[3] = '{5'b01000, 16'h0044, 16'h0000, 16'h5A5A, 1, 1'b1, 1'b0, 1'b1, 16'hA5C3, 16'h5A5A};
        vecs[4] = '{5'b10000, 16'h0045, 16'h7777, 16'h1111, 2, 1'b0, 1'b1, 1'b1, 16'hA5C3, 16'h5A5A};
        vecs[5] = '{5'b11111, 16'h0100, 16'h3333, 16'hBEEF, 0, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h5A5A};
        vecs[6] = '{5'b01100, 16'h0400, 16'h4444, 16'h2222, 0, 1'b0, 1'b1, 1'b0, 16'hBEEF, 16'h5A5A};

        rst_n     = 1'b0;
        set_reqs(5'b0);
        addr      = 16'hFFFF;
        wdata     = 16'hFFFF;
        bus_rdata = 16'hFFFF;
        bus_ready = 1'b0;
        #1;
        check("reset strobes", {busy, bus_rd, bus_wr, bus_io, done, err}, 6'b0);
        check("reset instr/rdata", {instr, rdata}, 32'h0);
        check("reset bus addr/wdata", {bus_addr, bus_wdata}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            txn($sformatf("vec%0d", i), vecs[i].reqs, vecs[i].a, vecs[i].w, vecs[i].brd,
                vecs[i].waits, vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_io,
                vecs[i].e_instr, vecs[i].e_rdata);
        m_instr = 16'hBEEF;
        m_rdata = 16'h5A5A;

        // Reset in the second ACCESS cycle of an IN.
        set_reqs(5'b01000);
        addr      = 16'h0055;
        wdata     = 16'h6666;
        bus_rdata = 16'h9999;
        bus_ready = 1'b0;
        @(negedge clk);
        set_reqs(5'b0);
        @(negedge clk);
        check("rst-mid in strobes", {busy, bus_rd, bus_wr, bus_io}, 4'b1101);
        rst_n = 1'b0;
        #1;
        check("rst-mid strobes", {busy, bus_rd, bus_wr, bus_io, done, err}, 6'b0);
        check("rst-mid regs", {instr, rdata, bus_addr, bus_wdata}, 64'h0);
        bus_ready = 1'b1;
        @(negedge clk);
        check("rst-mid no done", {done, err, busy}, 3'b0);
        rst_n     = 1'b1;
        bus_ready = 1'b0;
        m_instr   = 16'h0;
        m_rdata   = 16'h0;
        txn("post-reset fetch", 5'b00001, 16'h0020, 16'h0000, 16'hC001, 0,
            1'b1, 1'b0, 1'b0, 16'hC001, 16'h0000);
        m_instr = 16'hC001;

        // Back-to-back fetch with request held high.
        begin
            int pulses = 0;
            set_reqs(5'b00001);
            addr      = 16'h0030;
            bus_rdata = 16'h7E7E;
            bus_ready = 1'b1;
            for (int c = 1; c <= 9; c++) begin
                @(negedge clk);
                check($sformatf("b2b done c%0d", c), done, (c % 3) == 2);
                check($sformatf("b2b busy c%0d", c), busy, (c % 3) != 0);
                if (done) pulses++;
            end
            check("b2b pulse count", pulses, 3);
            check("b2b instr", instr, 16'h7E7E);
            set_reqs(5'b0);
            bus_ready = 1'b0;
            @(negedge clk);
            @(negedge clk);
            m_instr = 16'h7E7E;
        end

        // Long wait: timeout aborts when enabled, otherwise ACCESS persists.
        set_reqs(5'b01000);
        addr      = 16'h0066;
        bus_rdata = 16'h4321;
        bus_ready = 1'b0;
        @(negedge clk);
        set_reqs(5'b0);
`ifdef MEM_PORT_TIMEOUT_EN
        for (int c = 1; c <= 6; c++) begin
            check($sformatf("timeout busy c%0d", c), busy, c <= 4);
            check($sformatf("timeout err c%0d", c), err, c == 5);
            check($sformatf("timeout done c%0d", c), done, 1'b0);
            @(negedge clk);
        end
        check("timeout regs kept", {instr, rdata}, {m_instr, m_rdata});
`else
        for (int c = 1; c <= 10; c++) begin
            check($sformatf("longwait c%0d", c), {busy, bus_rd, bus_io, done, err}, 5'b11100);
            @(negedge clk);
        end
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        check("longwait done", {done, rdata}, {1'b1, 16'h4321});
        m_rdata = 16'h4321;
        @(negedge clk);
`endif

        // Random traffic against the reference model.
        for (int t = 0; t < 40; t++) begin
            logic [4:0]  r;
            logic [15:0] a, w, brd;
            int          k, wt;
            r   = 5'($urandom_range(1, 31));
            a   = 16'($urandom);
            w   = 16'($urandom);
            brd = 16'($urandom);
            wt  = $urandom_range(0, WMAX);
            k   = winner(r);
            if (k == 0) m_instr = brd;
            else if (k == 1 || k == 3) m_rdata = brd;
            txn($sformatf("rnd%0d", t), r, a, w, brd, wt, rd_set[k], wr_set[k], io_set[k],
                m_instr, m_rdata);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
